// File: rtl/ccastles_pkg.sv
// Shared constants and types for the interrupt / watchdog / CPU reset control.
//   INTACK_ADDR_C  : CPU write address that acknowledges the interrupt
//   WDOG_ADDR_C    : CPU write address that kicks the watchdog
//   IRQ_VBIT_C     : bit of the vertical counter driven out as IRQCLK
//   WDOG_FRAMES_C  : VBLANK rising edges without a kick before the bite
//   RESET_CYCLES_C : clk cycles the CPU reset is stretched
//   stretch_state_t: HOLD (CPU held in reset) / RUN
package ccastles_pkg;

  localparam logic [15:0] INTACK_ADDR_C  = 16'h9600;
  localparam logic [15:0] WDOG_ADDR_C    = 16'h9500;
  localparam int unsigned IRQ_VBIT_C     = 5;
  localparam int unsigned WDOG_FRAMES_C  = 8;
  localparam int unsigned RESET_CYCLES_C = 16;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } stretch_state_t;

endpackage

// File: rtl/irq_watchdog_ctrl_reset_stretcher.sv
// reset_stretcher: holds rst_n_out low for RESET_CYCLES clk cycles after
// reset release or after a trigger pulse, then releases it.
//   clk       : system clock
//   reset     : asynchronous, active-high reset (enters HOLD, full count)
//   trigger   : restart the stretch (watchdog bite)
//   rst_n_out : active-low reset to the CPU, registered
module reset_stretcher
  import ccastles_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_C
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic rst_n_out
);

  localparam int unsigned    CW   = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0]  LOAD = CW'(RESET_CYCLES);

  stretch_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (trigger) begin
      state_d = HOLD;
      cnt_d   = LOAD;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q - 1'b1;
      // The edge that takes the count to zero also enters RUN, so the
      // output is low for exactly RESET_CYCLES edges.
      if (cnt_q == CW'(1)) begin
        state_d = RUN;
      end
    end
  end

  // Decode of a single state flop: glitch-free, effectively registered.
  assign rst_n_out = (state_q == RUN);

endmodule

// File: rtl/irq_watchdog_ctrl.sv
// irq_watchdog_ctrl: interrupt clock, interrupt acknowledge, frame-counting
// watchdog and stretched CPU reset for the 65C02 stage.
//   clk, reset  : system clock, asynchronous active-high reset
//   ce2H        : CPU bus cycle valid
//   BA, BRWn    : CPU address bus, read/write (0 = write)
//   V, VBLANK   : vertical line counter, vertical blank level
//   IRQCLK      : V[IRQ_VBIT] delayed one clk
//   INTACKn     : one-cycle low strobe after a write to INTACK_ADDR
//   cpu_reset_n : active-low CPU reset, stretched after reset and bites
//   wdog_bite   : one-cycle pulse when the watchdog fires
module irq_watchdog_ctrl
  import ccastles_pkg::*;
#(
  parameter logic [15:0] INTACK_ADDR  = INTACK_ADDR_C,
  parameter logic [15:0] WDOG_ADDR    = WDOG_ADDR_C,
  parameter int unsigned IRQ_VBIT     = IRQ_VBIT_C,
  parameter int unsigned WDOG_FRAMES  = WDOG_FRAMES_C,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce2H,
  input  logic [15:0] BA,
  input  logic        BRWn,
  input  logic [7:0]  V,
  input  logic        VBLANK,
  output logic        IRQCLK,
  output logic        INTACKn,
  output logic        cpu_reset_n,
  output logic        wdog_bite
);

  logic       wr;
  logic       intack_wr;
  logic       kick;
  logic       vb_q;
  logic       vb_rise;
  logic       bite_now;
  logic [3:0] wd_cnt;

  // Writes only count while the CPU is out of reset.
  assign wr        = ce2H & ~BRWn & cpu_reset_n;
  assign intack_wr = wr & (BA == INTACK_ADDR);
  assign kick      = wr & (BA == WDOG_ADDR);
  assign vb_rise   = VBLANK & ~vb_q;

  // Bite replaces the increment that would reach WDOG_FRAMES; a kick in the
  // same cycle wins.
  assign bite_now  = cpu_reset_n & ~kick & vb_rise &
                     (wd_cnt == 4'(WDOG_FRAMES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IRQCLK    <= 1'b0;
      INTACKn   <= 1'b1;
      wdog_bite <= 1'b0;
      vb_q      <= 1'b1;
      wd_cnt    <= '0;
    end else begin
      IRQCLK    <= V[IRQ_VBIT];
      INTACKn   <= ~intack_wr;
      wdog_bite <= bite_now;
      vb_q      <= VBLANK;
      if (!cpu_reset_n || kick || bite_now) begin
        wd_cnt <= '0;
      end else if (vb_rise) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  reset_stretcher #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_stretch (
    .clk      (clk),
    .reset    (reset),
    .trigger  (bite_now),
    .rst_n_out(cpu_reset_n)
  );

endmodule

// File: tb/tb_irq_watchdog_ctrl.sv
module tb_irq_watchdog_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce2H = 1'b0;
  logic [15:0] BA = '0;
  logic        BRWn = 1'b1;
  logic [7:0]  V = '0;
  logic        VBLANK = 1'b0;
  logic        IRQCLK, INTACKn, cpu_reset_n, wdog_bite;

  int checks = 0;
  int errors = 0;
  bit release_now = 1'b0;

  typedef struct {
    string name;
    logic  irq;
    logic  intackn;
    logic  rstn;
    logic  bite;
  } exp_t;

  typedef struct {
    string       name;
    logic        ce;
    logic        brwn;
    logic [15:0] ba;
    logic [7:0]  v;
    logic        vb;
    logic        e_intackn;
    logic        e_rstn;
    logic        e_bite;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  irq_watchdog_ctrl #(
    .INTACK_ADDR (16'h9600),
    .WDOG_ADDR   (16'h9500),
    .IRQ_VBIT    (5),
    .WDOG_FRAMES (8),
    .RESET_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce2H       (ce2H),
    .BA         (BA),
    .BRWn       (BRWn),
    .V          (V),
    .VBLANK     (VBLANK),
    .IRQCLK     (IRQCLK),
    .INTACKn    (INTACKn),
    .cpu_reset_n(cpu_reset_n),
    .wdog_bite  (wdog_bite)
  );

  initial begin
    #1ms;
    $display("FAIL timeout got running want finished");
    $fatal(1, "simulation time limit");
  end

  function automatic logic irq_of(input logic [7:0] v);
    return ((v % 8'd64) >= 8'd32);
  endfunction

  task automatic cmp1(input string name, input string sig, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got %b want %b", name, sig, act, exp);
    end
  endtask

  task automatic check_pending();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp1(e.name, "IRQCLK", IRQCLK, e.irq);
      cmp1(e.name, "INTACKn", INTACKn, e.intackn);
      cmp1(e.name, "cpu_reset_n", cpu_reset_n, e.rstn);
      cmp1(e.name, "wdog_bite", wdog_bite, e.bite);
    end
  endtask

  task automatic check_reset_values(input string name);
    cmp1(name, "IRQCLK", IRQCLK, 1'b0);
    cmp1(name, "INTACKn", INTACKn, 1'b1);
    cmp1(name, "cpu_reset_n", cpu_reset_n, 1'b0);
    cmp1(name, "wdog_bite", wdog_bite, 1'b0);
  endtask

  // Drive one cycle of inputs at the falling edge; the expectation is for
  // the outputs after the following rising edge.
  task automatic step(input logic ce, input logic brwn, input logic [15:0] ba,
                      input logic [7:0] v, input logic vb, input logic e_intackn,
                      input logic e_rstn, input logic e_bite, input string name);
    exp_t e;
    @(negedge clk);
    check_pending();
    if (release_now) begin
      reset = 1'b0;
      release_now = 1'b0;
    end
    ce2H = ce; BRWn = brwn; BA = ba; V = v; VBLANK = vb;
    e.name = name; e.irq = irq_of(v); e.intackn = e_intackn;
    e.rstn = e_rstn; e.bite = e_bite;
    sb.push_back(e);
  endtask

  task automatic idle(input string name, input logic [7:0] v, input logic vb, input logic e_rstn);
    step(1'b0, 1'b1, 16'h0000, v, vb, 1'b1, e_rstn, 1'b0, name);
  endtask

  task automatic frame(input string name, input logic with_kick);
    if (with_kick) step(1'b1, 1'b0, 16'h9500, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, name);
    else           idle(name, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(name, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic bite_frame(input string name, input logic with_intack);
    if (with_intack) step(1'b1, 1'b0, 16'h9600, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, name);
    else             idle_bite(name);
  endtask

  task automatic idle_bite(input string name);
    step(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, name);
  endtask

  task automatic hold_wait(input string name);
    for (int i = 0; i < 15; i++) idle(name, 8'h00, 1'b0, 1'b0);
    idle({name, "_release"}, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_vals");

    // Power-up stretch: 15 cycles low, released on the 16th edge
    release_now = 1'b1;
    hold_wait("powerup_hold");
    idle("powerup_run", 8'h00, 1'b0, 1'b1);

    // Bus decode vectors
    tbl[0] = '{"intack_wr",  1'b1, 1'b0, 16'h9600, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{"intack_end", 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{"read_9600",  1'b1, 1'b1, 16'h9600, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{"no_ce",      1'b0, 1'b0, 16'h9600, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{"addr_9601",  1'b1, 1'b0, 16'h9601, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{"b2b_1",      1'b1, 1'b0, 16'h9600, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{"b2b_2",      1'b1, 1'b0, 16'h9600, 8'h3F, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{"b2b_end",    1'b0, 1'b1, 16'h0000, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{"kick_idle",  1'b1, 1'b0, 16'h9500, 8'hE0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{"v_df",       1'b0, 1'b1, 16'h0000, 8'hDF, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++)
      step(tbl[i].ce, tbl[i].brwn, tbl[i].ba, tbl[i].v, tbl[i].vb,
           tbl[i].e_intackn, tbl[i].e_rstn, tbl[i].e_bite, tbl[i].name);

    // IRQCLK sweep
    for (int i = 0; i < 256; i++) idle("vsweep", 8'(i), 1'b0, 1'b1);

    // Watchdog bite after 8 unkicked VBLANK edges
    for (int f = 0; f < 7; f++) frame("wd_count", 1'b0);
    bite_frame("wd_bite", 1'b0);
    // Inside the hold: VBLANK edges, writes ignored; IRQCLK still tracks V
    for (int k = 1; k <= 15; k++) begin
      logic vbk;
      vbk = (k == 2 || k == 3 || k == 6 || k == 7 || k == 10 || k == 11);
      if (k == 3)      step(1'b1, 1'b0, 16'h9600, 8'(k * 16), vbk, 1'b1, 1'b0, 1'b0, "hold_wr_intack");
      else if (k == 5) step(1'b1, 1'b0, 16'h9500, 8'(k * 16), vbk, 1'b1, 1'b0, 1'b0, "hold_wr_kick");
      else             idle("hold_v", 8'(k * 16), vbk, 1'b0);
    end
    idle("bite_release", 8'h00, 1'b0, 1'b1);

    // Counter restarted at 0: 7 edges quiet, 8th bites; INTACKn low during bite
    for (int f = 0; f < 7; f++) frame("wd_restart", 1'b0);
    bite_frame("bite_intack", 1'b1);
    hold_wait("bite2_hold");

    // Kicks every 7th frame, kick coinciding with the rising edge
    for (int f = 1; f <= 100; f++) frame("kick_run", (f % 7) == 0);
    for (int f = 0; f < 5; f++) frame("kick_tail", 1'b0);
    bite_frame("kick_tail_bite", 1'b0);
    hold_wait("bite3_hold");

    // Reset in the middle of a bite hold
    for (int f = 0; f < 7; f++) frame("pre_rst", 1'b0);
    bite_frame("pre_rst_bite", 1'b0);
    for (int i = 0; i < 5; i++) idle("pre_rst_hold", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check_pending();
    V = 8'h20;
    reset = 1'b1;
    #1;
    check_reset_values("midhold_reset");
    @(posedge clk);
    #1;
    check_reset_values("midhold_reset_clk");
    V = 8'h00;
    release_now = 1'b1;
    hold_wait("rerelease_hold");
    idle("rerelease_run", 8'h00, 1'b0, 1'b1);

    @(negedge clk);
    check_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
